// File: rtl/muxn_pipe.sv
// Registered N-way select stage with valid/ready handshake and a two-entry skid buffer.
// Out-of-range selects yield zero, are flagged per result and counted in a saturating counter.
module muxn_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 10,
  parameter int SELW  = 4,
  parameter int CNTW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SELW-1:0]    s,
  input  logic [N*WIDTH-1:0] d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               bad_sel,
  output logic [CNTW-1:0]    err_cnt,
  input  logic               err_clr
);

  localparam int unsigned NU = N;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             bad_q, bad_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_y_q, skid_y_d;
  logic             skid_bad_q, skid_bad_d;
  logic [CNTW-1:0]  err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] sel_y;
  logic             sel_bad;
  logic             accept;

  always_comb begin
    sel_y   = '0;
    sel_bad = (32'(s) >= NU);
    for (int unsigned k = 0; k < NU; k++) begin
      if (32'(s) == k) sel_y = d[k*WIDTH +: WIDTH];
    end
  end

  assign accept = in_valid & ~skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    y_d          = y_q;
    bad_d        = bad_q;
    skid_valid_d = skid_valid_q;
    skid_y_d     = skid_y_q;
    skid_bad_d   = skid_bad_q;
    err_cnt_d    = err_cnt_q;

    // A full skid entry blocks intake, so only the drain path applies there.
    if (skid_valid_q) begin
      if (out_ready) begin
        out_valid_d  = 1'b1;
        y_d          = skid_y_q;
        bad_d        = skid_bad_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        y_d         = sel_y;
        bad_d       = sel_bad;
      end else begin
        skid_valid_d = 1'b1;
        skid_y_d     = sel_y;
        skid_bad_d   = sel_bad;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (err_clr) begin
      err_cnt_d = (accept && sel_bad) ? CNTW'(1) : '0;
    end else if (accept && sel_bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      y_q          <= '0;
      bad_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_y_q     <= '0;
      skid_bad_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      y_q          <= y_d;
      bad_q        <= bad_d;
      skid_valid_q <= skid_valid_d;
      skid_y_q     <= skid_y_d;
      skid_bad_q   <= skid_bad_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign bad_sel   = bad_q;
  assign err_cnt   = err_cnt_q;

endmodule
